// File: rtl/tiny_dnn_pkg.sv
// Purpose: shared widths and arithmetic helpers for the tiny DNN MAC array.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: default widths, sat_add() for optional saturation, relu() clamp.
package tiny_dnn_pkg;

  localparam int LANES_DEF  = 4;
  localparam int F_SIZE_DEF = 1024;
  localparam int DW_DEF     = 16;
  localparam int WW_DEF     = 16;
  localparam int AW_DEF     = 40;

  // Internal arithmetic width; accumulators up to 62 bits add without
  // losing the true sum, so overflow can be detected after the add.
  localparam int CW = 64;

  // a and b are sign-extended accumulator-range values. With en set the
  // result is clamped to the signed aw-bit range. Otherwise the raw sum is
  // returned and the caller's truncation to aw bits gives the wrap.
  function automatic logic signed [CW-1:0] sat_add(input logic signed [CW-1:0] a,
                                                   input logic signed [CW-1:0] b,
                                                   input int                   aw,
                                                   input logic                 en);
    logic signed [CW-1:0] s;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    s  = a + b;
    hi = (64'sd1 <<< (aw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (en && (s > hi)) return hi;
    if (en && (s < lo)) return lo;
    return s;
  endfunction

  function automatic logic signed [CW-1:0] relu(input logic signed [CW-1:0] x);
    return x[CW-1] ? '0 : x;
  endfunction

endpackage

// File: rtl/tiny_dnn_mac_lane.sv
// Purpose: one output neuron: weight bank, read register and 3-stage MAC.
// Latency: op issued at t updates acc at the end of t+2 (visible t+3).
// Backpressure: none; accepts one op per cycle, never stalls.
// Ports: we/waddr/wd weight write; re/raddr stage-1 read; d activation
//        (one cycle after issue); init2/exec2/bias2 stage-3 controls from
//        the shared pipeline; sat_en saturation; acc accumulator out.
module tiny_dnn_mac_lane
  import tiny_dnn_pkg::*;
#(
  parameter int F_SIZE = F_SIZE_DEF,
  parameter int AB     = $clog2(F_SIZE_DEF),
  parameter int DW     = DW_DEF,
  parameter int WW     = WW_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 we,
  input  logic [AB-1:0]        waddr,
  input  logic signed [WW-1:0] wd,
  input  logic                 re,
  input  logic [AB-1:0]        raddr,
  input  logic signed [DW-1:0] d,
  input  logic                 init2,
  input  logic                 exec2,
  input  logic                 bias2,
  input  logic                 sat_en,
  output logic signed [AW-1:0] acc
);

  logic signed [WW-1:0] mem [F_SIZE];

  logic signed [WW-1:0] rd_q, rd_d;
  logic signed [WW-1:0] w2_q, w2_d;
  logic signed [DW-1:0] d2_q, d2_d;
  logic signed [AW-1:0] acc_q, acc_d;

  logic signed [DW+WW-1:0] prod;

  // Weight memory is not reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wd;
  end

  always_comb begin
    // Single-port bank: a write to this lane wins and the read register
    // keeps its previous word for the op issued in the same cycle.
    rd_d = (re && !we) ? mem[raddr] : rd_q;
    w2_d = rd_q;
    d2_d = d;

    // Full-precision signed product; low bits of an unsigned multiply of
    // sign-extended operands equal the signed product.
    prod = $signed({{WW{d2_q[DW-1]}}, d2_q}) * $signed({{DW{w2_q[WW-1]}}, w2_q});

    acc_d = acc_q;
    if (init2) begin
      acc_d = '0;
    end else if (exec2) begin
      acc_d = AW'(sat_add(CW'(acc_q), CW'(prod), AW, sat_en));
    end else if (bias2) begin
      acc_d = AW'(sat_add(CW'(acc_q), CW'(w2_q), AW, sat_en));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      w2_q  <= '0;
      d2_q  <= '0;
      acc_q <= '0;
    end else begin
      rd_q  <= rd_d;
      w2_q  <= w2_d;
      d2_q  <= d2_d;
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/tiny_dnn_mac_array.sv
// Purpose: LANES parallel MAC neurons with shared control and readout chain.
// Latency: exec/bias at t -> result on sum and acc_valid at t+3.
// Backpressure: none; one op per cycle, fully pipelined.
// Ports: write/bwrite/wlane/wa/wd weight load; exec/bias/ra/d ops; init
//        clear; sat_en/relu_en/update view control; outr/sum_in chain
//        load; sum lanes at [i*AW +: AW]; acc_valid result strobe.
module tiny_dnn_mac_array
  import tiny_dnn_pkg::*;
#(
  parameter int LANES  = LANES_DEF,
  parameter int F_SIZE = F_SIZE_DEF,
  parameter int DW     = DW_DEF,
  parameter int WW     = WW_DEF,
  parameter int AW     = AW_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         init,
  input  logic                         write,
  input  logic                         bwrite,
  input  logic [$clog2(LANES)-1:0]     wlane,
  input  logic [$clog2(F_SIZE)-1:0]    wa,
  input  logic [$clog2(F_SIZE)-1:0]    ra,
  input  logic signed [WW-1:0]         wd,
  input  logic                         exec,
  input  logic                         bias,
  input  logic signed [DW-1:0]         d,
  input  logic                         sat_en,
  input  logic                         relu_en,
  input  logic                         update,
  input  logic                         outr,
  input  logic [LANES*AW-1:0]          sum_in,
  output logic [LANES*AW-1:0]          sum,
  output logic                         acc_valid
);

  localparam int LB = $clog2(LANES);
  localparam int AB = $clog2(F_SIZE);
  localparam logic [AB-1:0] BIAS_ADDR = AB'(F_SIZE - 1);

  logic exec1_q, exec1_d, bias1_q, bias1_d, init1_q, init1_d;
  logic exec2_q, exec2_d, bias2_q, bias2_d, init2_q, init2_d;
  logic acc_valid_q, acc_valid_d;
  logic [LANES*AW-1:0] sh_q, sh_d;

  logic [AB-1:0] raddr, waddr;
  logic signed [AW-1:0] lane_acc [LANES];

  always_comb begin
    // exec with bias is an exec whose weight comes from the bias word.
    raddr   = bias ? BIAS_ADDR : ra;
    waddr   = bwrite ? BIAS_ADDR : wa;
    exec1_d = exec;
    bias1_d = bias && !exec;
    init1_d = init;
    exec2_d = exec1_q;
    bias2_d = bias1_q;
    init2_d = init1_q;
    // A clear landing with an op overrides it, so no result is reported.
    acc_valid_d = (exec2_q || bias2_q) && !init2_q;
    sh_d = outr ? sum_in : sh_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exec1_q     <= 1'b0;
      bias1_q     <= 1'b0;
      init1_q     <= 1'b0;
      exec2_q     <= 1'b0;
      bias2_q     <= 1'b0;
      init2_q     <= 1'b0;
      acc_valid_q <= 1'b0;
      sh_q        <= '0;
    end else begin
      exec1_q     <= exec1_d;
      bias1_q     <= bias1_d;
      init1_q     <= init1_d;
      exec2_q     <= exec2_d;
      bias2_q     <= bias2_d;
      init2_q     <= init2_d;
      acc_valid_q <= acc_valid_d;
      sh_q        <= sh_d;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    tiny_dnn_mac_lane #(
      .F_SIZE(F_SIZE), .AB(AB), .DW(DW), .WW(WW), .AW(AW)
    ) u_lane (
      .clk   (clk),
      .reset (reset),
      .we    (write && (wlane == LB'(i))),
      .waddr (waddr),
      .wd    (wd),
      .re    (exec || bias),
      .raddr (raddr),
      .d     (d),
      .init2 (init2_q),
      .exec2 (exec2_q),
      .bias2 (bias2_q),
      .sat_en(sat_en),
      .acc   (lane_acc[i])
    );
  end

  always_comb begin
    sum = sh_q;
    if (update) begin
      for (int i = 0; i < LANES; i++) begin
        sum[i*AW +: AW] = relu_en ? AW'(relu(CW'(lane_acc[i]))) : lane_acc[i];
      end
    end
  end

  assign acc_valid = acc_valid_q;

endmodule

// File: tb/tb_tiny_dnn_mac_array.sv
module tb_tiny_dnn_mac_array;

  localparam int LANES = 4;
  localparam int F_SIZE = 1024;
  localparam int DW = 16;
  localparam int WW = 16;
  localparam int AW = 40;
  localparam int SW = LANES * AW;

  localparam longint P    = 64'sd1073676289;   // 32767 * 32767
  localparam longint MAXV = 64'sd549755813887;  // 2^39 - 1
  localparam longint WRAP = -64'sd548715691519; // 513*P - 2^40

  logic clk, reset, init, write, bwrite, exec, bias, sat_en, relu_en, update, outr;
  logic [1:0] wlane;
  logic [9:0] wa, ra;
  logic [15:0] wd, d, d_pend;
  logic [SW-1:0] sum_in, sum;
  logic acc_valid;

  int cyc = 0;
  int nchk = 0;
  int nbad = 0;

  typedef struct {
    logic [SW-1:0] v;
    int            c;
  } exp_t;
  exp_t q[$];

  tiny_dnn_mac_array #(
    .LANES(LANES), .F_SIZE(F_SIZE), .DW(DW), .WW(WW), .AW(AW)
  ) dut (
    .clk(clk), .reset(reset), .init(init), .write(write), .bwrite(bwrite),
    .wlane(wlane), .wa(wa), .ra(ra), .wd(wd), .exec(exec), .bias(bias),
    .d(d), .sat_en(sat_en), .relu_en(relu_en), .update(update), .outr(outr),
    .sum_in(sum_in), .sum(sum), .acc_valid(acc_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [SW-1:0] pk(input longint a0, input longint a1,
                                       input longint a2, input longint a3);
    logic [SW-1:0] r;
    r[0*AW +: AW] = a0[AW-1:0];
    r[1*AW +: AW] = a1[AW-1:0];
    r[2*AW +: AW] = a2[AW-1:0];
    r[3*AW +: AW] = a3[AW-1:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [SW-1:0] act, input logic [SW-1:0] want);
    nchk++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // Scoreboard monitor: every acc_valid pulse must match the oldest
  // expectation in both value and cycle.
  always @(negedge clk) begin
    if (acc_valid === 1'b1) begin
      if (q.size() == 0) begin
        nchk++;
        nbad++;
        $display("FAIL unexpected_acc_valid cyc=%0d sum=%h want=no_result", cyc, sum);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("acc_sum", sum, e.v);
        nchk++;
        if (cyc != e.c) begin
          nbad++;
          $display("FAIL acc_valid_cycle got=%0d want=%0d", cyc, e.c);
        end
      end
    end
  end

  task automatic push(input logic [SW-1:0] v);
    exp_t e;
    e.v = v;
    e.c = cyc + 3;
    q.push_back(e);
  endtask

  task automatic wr(input int lane, input int addr, input bit bw, input longint val);
    write = 1'b1; wlane = 2'(lane); wa = 10'(addr); bwrite = bw; wd = 16'(val);
    @(posedge clk); #1;
    write = 1'b0; bwrite = 1'b0;
  endtask

  // One cycle of op issue; d carries the activation of the previous cycle's op.
  task automatic op(input bit e, input bit b, input bit i, input int r, input longint dv);
    exec = e; bias = b; init = i; ra = 10'(r);
    d = d_pend; d_pend = 16'(dv);
    @(posedge clk); #1;
    exec = 1'b0; bias = 1'b0; init = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) op(1'b0, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    longint v;
    reset = 1'b1; init = 1'b0; write = 1'b0; bwrite = 1'b0; exec = 1'b0; bias = 1'b0;
    sat_en = 1'b0; relu_en = 1'b0; update = 1'b1; outr = 1'b0;
    wlane = '0; wa = '0; ra = '0; wd = '0; d = '0; d_pend = '0; sum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_sum", sum, '0);
    chk("reset_acc_valid", SW'(acc_valid), '0);
    reset = 1'b0;
    idle(2);

    // Basic MAC after init.
    wr(0, 0, 1'b0, 2); wr(1, 0, 1'b0, 3); wr(2, 0, 1'b0, -4); wr(3, 0, 1'b0, 5);
    op(1'b0, 1'b0, 1'b1, 0, 0);
    push(pk(20, 30, -40, 50)); op(1'b1, 1'b0, 1'b0, 0, 10);
    idle(4);

    // Bias add, relu view, exec+bias treated as exec on the bias word.
    for (int l = 0; l < 4; l++) wr(l, 3, 1'b1, 7);
    push(pk(27, 37, -33, 57)); op(1'b0, 1'b1, 1'b0, 0, 0);
    idle(4);
    relu_en = 1'b1; #1;
    chk("relu_view", sum, pk(27, 37, 0, 57));
    relu_en = 1'b0; #1;
    chk("no_relu_view", sum, pk(27, 37, -33, 57));
    push(pk(41, 51, -19, 71)); op(1'b1, 1'b1, 1'b0, 0, 2);
    idle(4);

    // Write/read collision on lane 1.
    wr(0, 5, 1'b0, 1); wr(1, 5, 1'b0, 11); wr(2, 5, 1'b0, 2); wr(3, 5, 1'b0, 3);
    op(1'b0, 1'b0, 1'b1, 0, 0);
    push(pk(1, 11, 2, 3)); op(1'b1, 1'b0, 1'b0, 5, 1);
    write = 1'b1; wlane = 2'd1; wa = 10'd5; wd = 16'd100;
    push(pk(2, 22, 4, 6)); op(1'b1, 1'b0, 1'b0, 5, 1);
    write = 1'b0;
    push(pk(3, 122, 6, 9)); op(1'b1, 1'b0, 1'b0, 5, 1);
    idle(4);

    // Back-to-back burst of 8: lane L weight k + 10*L at address 15+k.
    for (int k = 1; k <= 8; k++)
      for (int l = 0; l < 4; l++) wr(l, 15 + k, 1'b0, k + 10 * l);
    op(1'b0, 1'b0, 1'b1, 0, 0);
    for (int n = 1; n <= 8; n++) begin
      longint t;
      t = longint'(n * (n + 1) / 2);
      push(pk(t, t + 10 * n, t + 20 * n, t + 30 * n));
      op(1'b1, 1'b0, 1'b0, 15 + n, 1);
    end
    idle(4);
    chk("burst_final", sum, pk(36, 116, 196, 276));

    // Saturating accumulate toward +2^39-1.
    for (int l = 0; l < 4; l++) wr(l, 10, 1'b0, 32767);
    sat_en = 1'b1;
    op(1'b0, 1'b0, 1'b1, 0, 0);
    for (int n = 1; n <= 513; n++) begin
      v = (n <= 512) ? longint'(n) * P : MAXV;
      push(pk(v, v, v, v));
      op(1'b1, 1'b0, 1'b0, 10, 32767);
    end
    idle(4);
    chk("sat_clamp_hold", sum, pk(MAXV, MAXV, MAXV, MAXV));

    // Same sequence wrapping.
    sat_en = 1'b0;
    op(1'b0, 1'b0, 1'b1, 0, 0);
    for (int n = 1; n <= 513; n++) begin
      v = (n <= 512) ? longint'(n) * P : WRAP;
      push(pk(v, v, v, v));
      op(1'b1, 1'b0, 1'b0, 10, 32767);
    end
    idle(4);
    chk("wrap_final", sum, pk(WRAP, WRAP, WRAP, WRAP));

    // Reset one cycle after an exec drops it.
    op(1'b1, 1'b0, 1'b0, 0, 10);
    reset = 1'b1;
    idle(2);
    chk("midreset_sum", sum, '0);
    reset = 1'b0;
    idle(6);
    chk("post_reset_sum", sum, '0);
    chk("post_reset_acc_valid", SW'(acc_valid), '0);

    // Shift-register load from the chain input.
    update = 1'b0;
    sum_in = pk(1, 2, 3, 4);
    outr = 1'b1; #1;
    chk("shift_before_edge", sum, '0);
    @(posedge clk); #1;
    outr = 1'b0; sum_in = '0;
    chk("shift_load", sum, pk(1, 2, 3, 4));
    @(posedge clk); #1;
    chk("shift_hold", sum, pk(1, 2, 3, 4));
    update = 1'b1; #1;
    chk("acc_view_after_reset", sum, '0);

    idle(5);
    nchk++;
    if (q.size() != 0) begin
      nbad++;
      $display("FAIL queue_drain got=%0d pending want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", nchk, nbad);
    $finish;
  end

endmodule
